rf_dump: RTL and testbench
==========================

# rf_dump

Register-file readout sequencer: on a start pulse it walks the register file's read port over an address range `[first_addr, last_addr]` and streams each word out on a valid/ready interface. It sits between the CPU's 32×32 register file (driving one `raddr`/`rdata` pair) and the debug/trace path, and is the reading counterpart to the register-file write port. The register file's read is combinational, so this block owns all sequencing, backpressure and termination.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register/stream word width
- `ADDR_WIDTH`, 5, register address width (2^ADDR_WIDTH registers)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin a dump; sampled only in IDLE
- `first_addr`  in  ADDR_WIDTH  first register to read, latched on accepted `start`
- `last_addr`  in  ADDR_WIDTH  last register to read (inclusive), latched on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at dump completion
- `rf_raddr`  out  ADDR_WIDTH  register-file read address (registered)
- `rf_rdata`  in  DATA_WIDTH  register-file read data, combinational from `rf_raddr`
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream accepts word
- `out_data`  out  DATA_WIDTH  stream word
- `out_addr`  out  ADDR_WIDTH  register address of `out_data`
- `out_last`  out  1  final beat of the dump

## Operation
- States: IDLE, READ, SEND, DONE (plus CSUM when configured).
- IDLE: `start`=1 latches range; if `first_addr > last_addr` → DONE (empty dump, no beats); else `rf_raddr <= first_addr` → READ.
- READ (exactly one cycle): capture `rf_rdata` into `out_data`, `rf_raddr` into `out_addr`; set `out_valid`; `out_last` = (cur == last) and CSUM not configured → SEND.
- SEND: hold `out_valid`, `out_data`, `out_addr`, `out_last` stable until `out_valid && out_ready`. On handshake: not last → `rf_raddr <= rf_raddr + 1`, clear `out_valid`, → READ; last → clear `out_valid` → CSUM or DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Last-address detection is compare-based, not counter overflow: `last_addr = 31` terminates after address 31; `rf_raddr` never wraps to 0 within a dump.
- `first_addr = 0` emits a beat for address 0 with whatever `rf_rdata` returns (0 from the register file).
- `start` in any non-IDLE state is ignored; range inputs are don't-care outside the accepting cycle.
- Range inputs changing mid-dump have no effect.

## Timing
- Reset (async assert, any state): `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `rf_raddr`=0, state IDLE; in-flight beat is dropped without handshake.
- `start` at edge N → READ during cycle N+1 → first `out_valid` at N+2.
- Throughput with `out_ready` held high: one beat per 2 cycles; N-word dump: first beat at N+2, `done` one cycle after final handshake (plus one CSUM beat if configured).
- Empty range: `done` pulse in cycle N+1, `busy` high only that cycle.
- `out_valid` never deasserts without a handshake except on reset.

## Configuration
- `RF_DUMP_CSUM_EN` defined: after the last register beat, CSUM state emits one extra beat: `out_data` = XOR of all emitted register words, `out_addr` = 0, `out_last` = 1; register beats then all have `out_last` = 0. Empty range emits a single checksum beat of 0.
- Undefined: no CSUM state or accumulator; `out_last` marks the final register beat; empty range emits nothing.

## Structure
- Shared package: state encoding localparams (IDLE/READ/SEND/CSUM/DONE) and default width constants shared with `reg_file`.
- Checksum accumulator is a natural sub-module `rf_dump_csum` (clear on accepted start, XOR on handshake), instantiated only under `RF_DUMP_CSUM_EN`.

## Test plan
- Preload r1..r3 = 0x11, 0x22, 0x33; start range 1..3, ready=1 → beats (1,0x11), (2,0x22), (3,0x33,last), `done` one cycle after beat 3.
- Range 30..31, r30=0xDEAD_BEEF, r31=0xCAFE_F00D → two beats, addr 31 last, `rf_raddr` never reaches 0, `done` pulses once.
- Range 5..5 with `out_ready` low for 7 cycles → `out_valid`, data, addr stable all 7 cycles; single handshake then `done`.
- Range 4..2 → no beats, `done` at cycle after start; with `RF_DUMP_CSUM_EN` one beat data 0, last=1.
- Range 0..31, `start` re-pulsed mid-dump, async reset asserted at beat 10 → second start ignored; on reset `out_valid`, `busy` drop to 0 immediately; new start after release dumps from 0 normally.
- `RF_DUMP_CSUM_EN`, range 1..2 with 0xF0F0_0000, 0x0F0F_FFFF → third beat 0xFFFF_FFFF, addr 0, last=1.

Source files
------------

// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared widths and the state encoding of the register-file
// readout sequencer. The width defaults match the CPU register file
// (32 x 32). The package defines no build macros.
package rf_dump_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned STATE_WIDTH   = 3;

  // CSUM keeps its code in every build so the encoding matches across
  // configurations; the FSM never enters it unless the checksum is built in.
  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/rf_dump_if.sv
// rf_dump_if: the output word stream of rf_dump.
// valid/ready rule: a beat transfers on every rising clock edge where
// out_valid && out_ready. Once out_valid is high, out_valid, out_data,
// out_addr and out_last hold until that edge. out_ready may change freely.
interface rf_dump_if
  import rf_dump_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );

endinterface

// File: rtl/rf_dump_csum.sv
// rf_dump_csum: XOR accumulator over the words of one dump.
// rf_dump instantiates it only when RF_DUMP_CSUM_EN is defined.
module rf_dump_csum #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  xor_en,
  input  logic [DATA_WIDTH-1:0] xor_data,
  output logic [DATA_WIDTH-1:0] acc
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;

  // Clear has priority so a new dump always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (xor_en) begin
      acc_d = acc_q ^ xor_data;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/rf_dump.sv
// rf_dump: walks the register-file read port over [first_addr, last_addr]
// and streams each word out on a valid/ready interface (rf_dump_if).
// Optional build macro: RF_DUMP_CSUM_EN adds a trailing XOR checksum beat.
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  rf_dump_if.master             out,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  olast_q, olast_d;
  logic                  hs;

`ifdef RF_DUMP_CSUM_EN
  logic                  csum_clr;
  logic                  csum_xor;
  logic [DATA_WIDTH-1:0] csum_acc;

  rf_dump_csum #(.DATA_WIDTH(DATA_WIDTH)) u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (csum_clr),
    .xor_en   (csum_xor),
    .xor_data (data_q),
    .acc      (csum_acc)
  );
`endif

  assign hs = valid_q && out.out_ready;

  // Next-state and output-register logic. The dump ends on an address
  // compare, so rf_raddr never wraps past last_addr.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    last_d  = last_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    olast_d = olast_q;
`ifdef RF_DUMP_CSUM_EN
    csum_clr = 1'b0;
    csum_xor = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d = last_addr;
`ifdef RF_DUMP_CSUM_EN
          csum_clr = 1'b1;
`endif
          if (first_addr > last_addr) begin
`ifdef RF_DUMP_CSUM_EN
            // An empty range still gets a checksum beat, and its value is zero.
            data_d  = '0;
            addr_d  = '0;
            olast_d = 1'b1;
            valid_d = 1'b1;
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            raddr_d = first_addr;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        data_d  = rf_rdata;
        addr_d  = raddr_q;
        valid_d = 1'b1;
`ifdef RF_DUMP_CSUM_EN
        olast_d = 1'b0;
`else
        olast_d = (raddr_q == last_q);
`endif
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (hs) begin
          valid_d = 1'b0;
`ifdef RF_DUMP_CSUM_EN
          csum_xor = 1'b1;
`endif
          if (addr_q == last_q) begin
`ifdef RF_DUMP_CSUM_EN
            // Fold in the word being accepted on this edge.
            data_d  = csum_acc ^ data_q;
            addr_d  = '0;
            olast_d = 1'b1;
            valid_d = 1'b1;
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            raddr_d = raddr_q + ADDR_WIDTH'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. Reset drops any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      raddr_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      olast_q <= olast_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign rf_raddr      = raddr_q;
  assign out.out_valid = valid_q;
  assign out.out_data  = data_q;
  assign out.out_addr  = addr_q;
  assign out.out_last  = olast_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rf_dump.sv
// tb_rf_dump: self-checking bench for rf_dump. A behavioural register file
// answers rf_raddr combinationally. Expected beats {last, addr, data} are
// queued when a dump is started, and observed beats are compared against
// them. RF_DUMP_CSUM_EN, if defined, must match the RTL build.
module tb_rf_dump;
  import rf_dump_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = 1 + AW + DW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic          busy;
  logic          done;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  state_e        dbg_state;

  logic [DW-1:0] rf_mem [32];

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];

  int errors = 0;
  int checks = 0;

  rf_dump_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dif ();

  rf_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .out        (dif),
    .dbg_state  (dbg_state)
  );

  assign rf_rdata = rf_mem[rf_raddr];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Queue the expected beats for range a..b from the register-file model.
  task automatic push_exp(input int a, input int b);
    logic [DW-1:0] x;
    logic          lst;
    x = '0;
    for (int i = a; i <= b; i++) begin
`ifdef RF_DUMP_CSUM_EN
      lst = 1'b0;
`else
      lst = (i == b);
`endif
      exp_q.push_back({lst, AW'(i), rf_mem[i]});
      x = x ^ rf_mem[i];
    end
`ifdef RF_DUMP_CSUM_EN
    exp_q.push_back({1'b1, AW'(0), x});
`endif
  endtask

  // Raise start for the next edge and queue the expected beats.
  task automatic start_dump(input int a, input int b);
    @(negedge clk);
    start      = 1'b1;
    first_addr = AW'(a);
    last_addr  = AW'(b);
    push_exp(a, b);
  endtask

  // Sample once per negedge until the dump returns to idle. Cycle numbers
  // count from 1 = the cycle after the start edge. The range inputs are
  // scrambled every cycle to show the latched range is the one in use.
  task automatic run_dump(input int budget, input bit rand_ready,
                          output int first_valid_cyc, output int last_hs_cyc,
                          output int done_cyc, output int done_cnt,
                          output int busy_cyc, output bit raddr_zero);
    first_valid_cyc = -1;
    last_hs_cyc     = -1;
    done_cyc        = -1;
    done_cnt        = 0;
    busy_cyc        = 0;
    raddr_zero      = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start         = 1'b0;
      first_addr    = AW'($urandom_range(0, 31));
      last_addr     = AW'($urandom_range(0, 31));
      dif.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) busy_cyc++;
      if (busy && rf_raddr == '0) raddr_zero = 1'b1;
      if (dif.out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (dif.out_valid && dif.out_ready) begin
        obs_q.push_back({dif.out_last, dif.out_addr, dif.out_data});
        last_hs_cyc = c;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cnt > 0 && !busy) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, dif.out_valid, dif.out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, dif.out_valid, dif.out_last});
    end
    checks++;
    if ({dif.out_data, dif.out_addr, rf_raddr} !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%h addr=%h raddr=%h expected all 0", dif.out_data, dif.out_addr, rf_raddr);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int fv, lh, dc, dn, bc;
    bit rz;
    logic [BW-1:0] g, e;
    rf_mem[1] = 32'h11; rf_mem[2] = 32'h22; rf_mem[3] = 32'h33;
    start_dump(1, 3);
    run_dump(100, 1'b0, fv, lh, dc, dn, bc, rz);
    checks++;
    if (fv !== 2) begin errors++; $display("FAIL basic_first_valid_cycle: got %0d expected 2", fv); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
    checks++;
    if (dc !== lh + 1) begin errors++; $display("FAIL basic_done_latency: got cycle %0d expected %0d", dc, lh + 1); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL basic_beat: got %h expected %h", g, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_top_range();
    int fv, lh, dc, dn, bc;
    bit rz;
    logic [BW-1:0] g, e;
    rf_mem[30] = 32'hDEAD_BEEF; rf_mem[31] = 32'hCAFE_F00D;
    start_dump(30, 31);
    run_dump(100, 1'b1, fv, lh, dc, dn, bc, rz);
    checks++;
    if (rz !== 1'b0) begin errors++; $display("FAIL top_raddr_wrap: got raddr=0 while busy expected never"); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL top_done_count: got %0d expected 1", dn); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL top_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL top_beat: got %h expected %h", g, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int fv, lh, dc, dn, bc;
    bit rz, seen;
    logic [BW-1:0] g, e;
    logic [DW-1:0] d5;
    rf_mem[5] = 32'h5A5A_0105;
    d5 = rf_mem[5];
    dif.out_ready = 1'b0;
    start_dump(5, 5);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (dif.out_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_valid_timeout: got no out_valid expected within 10 cycles"); end
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      first_addr = AW'($urandom_range(0, 31));
      checks++;
      if ({dif.out_valid, dif.out_addr, dif.out_data} !== {1'b1, AW'(5), d5}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b a=%h d=%h expected v=1 a=05 d=%h", i, dif.out_valid, dif.out_addr, dif.out_data, d5);
      end
    end
    run_dump(100, 1'b0, fv, lh, dc, dn, bc, rz);
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", dn); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL stall_beat: got %h expected %h", g, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_empty_range();
    int fv, lh, dc, dn, bc;
    bit rz;
    logic [BW-1:0] g, e;
    int exp_done_cyc, exp_busy;
`ifdef RF_DUMP_CSUM_EN
    exp_done_cyc = 2; exp_busy = 2;
`else
    exp_done_cyc = 1; exp_busy = 1;
`endif
    start_dump(4, 2);
    run_dump(50, 1'b0, fv, lh, dc, dn, bc, rz);
    checks++;
    if (dc !== exp_done_cyc) begin errors++; $display("FAIL empty_done_cycle: got %0d expected %0d", dc, exp_done_cyc); end
    checks++;
    if (bc !== exp_busy) begin errors++; $display("FAIL empty_busy_cycles: got %0d expected %0d", bc, exp_busy); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL empty_done_count: got %0d expected 1", dn); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL empty_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL empty_beat: got %h expected %h", g, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_restart_and_reset();
    int fv, lh, dc, dn, bc, hs;
    bit rz, hit;
    logic [BW-1:0] g, e;
    start_dump(0, 31);
    hs  = 0;
    hit = 1'b0;
    for (int c = 1; c <= 200 && !hit; c++) begin
      @(negedge clk);
      start         = (c == 8);
      first_addr    = AW'(7);
      last_addr     = AW'(8);
      dif.out_ready = 1'b1;
      if (hs == 10 && dif.out_valid) begin
        hit   = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dif.out_valid, busy, done} !== 3'b000) begin
          errors++;
          $display("FAIL async_reset_flags: got v/busy/done=%b expected 000", {dif.out_valid, busy, done});
        end
        checks++;
        if ({dif.out_data, dif.out_addr, dif.out_last, rf_raddr} !== '0) begin
          errors++;
          $display("FAIL async_reset_regs: got d=%h a=%h l=%b ra=%h expected all 0", dif.out_data, dif.out_addr, dif.out_last, rf_raddr);
        end
      end else if (dif.out_valid && dif.out_ready) begin
        g = {dif.out_last, dif.out_addr, dif.out_data};
        e = exp_q.pop_front();
        hs++;
        checks++;
        if (g !== e) begin errors++; $display("FAIL restart_beat_%0d: got %h expected %h", hs - 1, g, e); end
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL restart_reach_beat10: got %0d beats expected 10 before timeout", hs); end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete();
    start_dump(0, 31);
    run_dump(300, 1'b0, fv, lh, dc, dn, bc, rz);
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL post_reset_done_count: got %0d expected 1", dn); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL post_reset_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL post_reset_beat: got %h expected %h", g, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // Range 1..2 with complementary patterns: with the checksum built in,
  // the trailing beat is 0xFFFF_FFFF at address 0.
  task automatic test_pair();
    int fv, lh, dc, dn, bc;
    bit rz;
    logic [BW-1:0] g, e;
    rf_mem[1] = 32'hF0F0_0000; rf_mem[2] = 32'h0F0F_FFFF;
    start_dump(1, 2);
    run_dump(100, 1'b0, fv, lh, dc, dn, bc, rz);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pair_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      g = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL pair_beat: got %h expected %h", g, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int fv, lh, dc, dn, bc, a, b;
    bit rz;
    logic [BW-1:0] g, e;
    for (int it = 0; it < 4; it++) begin
      a = $urandom_range(0, 31);
      b = $urandom_range(a, (a + 6 > 31) ? 31 : a + 6);
      start_dump(a, b);
      run_dump(300, 1'b1, fv, lh, dc, dn, bc, rz);
      checks++;
      if (dn !== 1) begin errors++; $display("FAIL rand_done_count_%0d: got %0d expected 1", it, dn); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_beat_count_%0d: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        g = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (g !== e) begin errors++; $display("FAIL rand_beat_%0d: got %h expected %h", it, g, e); end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    start         = 1'b0;
    first_addr    = '0;
    last_addr     = '0;
    dif.out_ready = 1'b1;
    rf_mem[0]     = '0;
    for (int i = 1; i < 32; i++) rf_mem[i] = $urandom;
    test_reset();
    test_basic();
    test_top_range();
    test_backpressure();
    test_empty_range();
    test_restart_and_reset();
    test_pair();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
